ifetch_queue: RTL and testbench

Instruction fetch and prefetch queue sitting directly upstream of the `Control` decoder. Issues sequential word fetches to instruction memory and buffers returned instructions in a small in-order FIFO. Presents the head instruction with its PC, and its `opcode`/`funct3`/`funct7` fields, to decode over a valid/ready handshake. Flushes on branch/jump redirect and discards the stale memory responses still in flight.

---
 rtl/ifq_pkg.sv | 19 +
 rtl/ifq_fifo.sv | 48 ++++
 rtl/ifetch_queue.sv | 127 ++++++++++++
 tb/tb_ifetch_queue.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue: the queue entry
// layout and the bit positions of the decode fields.
package ifq_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT7_MSB = 31;
  localparam int FUNCT7_LSB = 25;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO with flush, occupancy count and a head output.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  T              mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count decide what is valid,
  // so clearing the array would only cost a reset tree for nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction prefetch with an in-order queue feeding decode.
// Define IFQ_BYPASS_EN to present a response arriving at an empty queue in the same cycle.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
  output logic        io_inst_valid,
  input  logic        io_inst_ready,
  output logic [31:0] io_inst,
  output logic [31:0] io_inst_pc,
  output logic [6:0]  io_opcode,
  output logic [2:0]  io_funct3,
  output logic [6:0]  io_funct7
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   redirect_addr;
  logic [CW-1:0] q_count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] stale;
  logic [CW:0]   credit_used;
  logic [31:0]   pc_head;
  ifq_entry_t    q_head;
  ifq_entry_t    push_entry;
  ifq_entry_t    head_entry;
  logic          req_fire;
  logic          resp_live;
  logic          bypass;
  logic          head_valid;
  logic          q_push;
  logic          q_pop;

  assign credit_used       = {1'b0, q_count} + {1'b0, inflight};
  assign io_imem_req_valid = reset && (credit_used < DEPTH_W);
  assign redirect_addr     = io_redirect_pc & ~32'd3;
  assign io_imem_req_addr  = io_redirect_valid ? redirect_addr : fetch_pc;
  assign req_fire          = io_imem_req_valid && io_imem_req_ready;
  assign resp_live         = io_imem_resp_valid && (stale == '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = resp_live && (q_count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign head_valid    = (q_count != '0) || bypass;
  assign io_inst_valid = head_valid && !io_redirect_valid;
  assign q_push        = resp_live && !io_redirect_valid && !(bypass && io_inst_ready);
  assign q_pop         = io_inst_valid && io_inst_ready && !bypass;

  // NOTE: every field is given a default first so no path leaves a latch behind.
  always_comb begin
    push_entry      = '0;
    push_entry.inst = io_imem_resp_data;
    push_entry.pc   = pc_head;
    head_entry      = bypass ? push_entry : q_head;
  end

  assign io_inst    = head_valid ? head_entry.inst : '0;
  assign io_inst_pc = head_valid ? head_entry.pc : '0;
  assign io_opcode  = io_inst[OPCODE_MSB:OPCODE_LSB];
  assign io_funct3  = io_inst[FUNCT3_MSB:FUNCT3_LSB];
  assign io_funct7  = io_inst[FUNCT7_MSB:FUNCT7_LSB];

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (ifq_entry_t)
  ) u_inst_q (
    .clk       (clock),
    .rst_n     (reset),
    .flush     (io_redirect_valid),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  // PC FIFO is never flushed: stale responses still pop their PCs, and its
  // occupancy is exactly the number of requests awaiting a response.
  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [31:0])
  ) u_pc_q (
    .clk       (clock),
    .rst_n     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (io_imem_req_addr),
    .pop       (io_imem_resp_valid),
    .head      (pc_head),
    .count     (inflight)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      stale    <= '0;
    end else begin
      if (req_fire)               fetch_pc <= io_imem_req_addr + 32'd4;
      else if (io_redirect_valid) fetch_pc <= redirect_addr;

      // A request firing alongside the redirect belongs to the new stream.
      if (io_redirect_valid)
        stale <= inflight - CW'(io_imem_resp_valid);
      else if (io_imem_resp_valid && (stale != '0))
        stale <= stale - CW'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a fixed-latency instruction memory model.
// Expectations adapt to the IFQ_BYPASS_EN build where response latency differs.
`timescale 1ns/1ps
module tb_ifetch_queue;
  import ifq_pkg::*;

`ifdef IFQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clock;
  logic        reset;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic [31:0] io_inst;
  logic [31:0] io_inst_pc;
  logic [6:0]  io_opcode;
  logic [2:0]  io_funct3;
  logic [6:0]  io_funct7;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       pend[$];
  int          cyc;
  int          lat;
  int          fires;
  bit          use_fixed;
  logic [31:0] fixed_word;

  ifetch_queue dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_inst_valid      (io_inst_valid),
    .io_inst_ready      (io_inst_ready),
    .io_inst            (io_inst),
    .io_inst_pc         (io_inst_pc),
    .io_opcode          (io_opcode),
    .io_funct3          (io_funct3),
    .io_funct7          (io_funct7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return use_fixed ? fixed_word : {a[24:0], 7'h13};
  endfunction

  // One clock: record a request firing before the edge, then present any
  // response due in the new cycle just after the edge.
  task automatic cycle();
    resp_t r;
    @(negedge clock);
    if (io_imem_req_valid && io_imem_req_ready) begin
      r.data = mem_word(io_imem_req_addr);
      r.due  = cyc + lat;
      pend.push_back(r);
      fires++;
    end
    @(posedge clock);
    #1;
    cyc++;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = r.data;
    end
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    io_redirect_valid  = 1'b0;
    io_redirect_pc     = '0;
    io_inst_ready      = 1'b0;
    use_fixed          = 1'b0;
    fixed_word         = '0;
    pend.delete();
    fires = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    reset              = 1'b0;
    io_imem_req_ready  = 1'b1;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    io_redirect_valid  = 1'b0;
    io_redirect_pc     = '0;
    io_inst_ready      = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (io_imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_req_valid: got %b want 0", io_imem_req_valid);
    end
    total++;
    if (io_inst_valid !== 1'b0) begin
      bad++; $display("FAIL reset_inst_valid: got %b want 0", io_inst_valid);
    end
    total++;
    if ({io_inst, io_inst_pc} !== 64'h0) begin
      bad++; $display("FAIL reset_inst_pc: got %h %h want 0 0", io_inst, io_inst_pc);
    end
    total++;
    if ({io_opcode, io_funct3, io_funct7} !== 17'h0) begin
      bad++; $display("FAIL reset_fields: got %h %h %h want 0", io_opcode, io_funct3, io_funct7);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL release_first_req: got %b %h want 1 00000000",
                      io_imem_req_valid, io_imem_req_addr);
    end
  endtask

  // Sequential fetch with decode stalled, then draining one per cycle.
  task automatic test_stream();
    do_reset();
    lat = 1; io_imem_req_ready = 1'b1; io_inst_ready = 1'b0;
    cycle(); #1;
    total++;
    if (io_imem_req_addr !== 32'h4) begin
      bad++; $display("FAIL stream_addr1: got %h want 00000004", io_imem_req_addr);
    end
    total++;
    if (io_inst_valid !== 1'(BYP)) begin
      bad++; $display("FAIL stream_latency: got %b want %0d", io_inst_valid, BYP);
    end
    cycle(); #1;
    total++;
    if ({io_inst_valid, io_inst_pc, io_inst} !== {1'b1, 32'h0, INST_NOP}) begin
      bad++; $display("FAIL stream_first_inst: got %b %h %h want 1 00000000 %h",
                      io_inst_valid, io_inst_pc, io_inst, INST_NOP);
    end
    total++;
    if (io_opcode !== 7'h13) begin
      bad++; $display("FAIL stream_opcode: got %h want 13", io_opcode);
    end
    total++;
    if (io_imem_req_addr !== 32'h8) begin
      bad++; $display("FAIL stream_addr2: got %h want 00000008", io_imem_req_addr);
    end
    repeat (3) cycle();
    #1;
    total++;
    if (io_imem_req_valid !== 1'b0 || fires !== 4) begin
      bad++; $display("FAIL stall_credit: got valid=%b fires=%0d want 0 4", io_imem_req_valid, fires);
    end
    total++;
    if (io_inst_pc !== 32'h0) begin
      bad++; $display("FAIL stall_head_stable: got %h want 00000000", io_inst_pc);
    end
    io_inst_ready = 1'b1;
    cycle(); #1;
    total++;
    if ({io_imem_req_valid, io_imem_req_addr, io_inst_pc} !== {1'b1, 32'h10, 32'h4}) begin
      bad++; $display("FAIL drain_fifth_req: got %b %h pc=%h want 1 00000010 pc=00000004",
                      io_imem_req_valid, io_imem_req_addr, io_inst_pc);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(); #1;
      total++;
      if ({io_inst_valid, io_inst_pc, io_inst} !==
          {1'b1, 32'(8 + 4 * k), mem_word(32'(8 + 4 * k))}) begin
        bad++; $display("FAIL drain_pop%0d: got %b %h %h want 1 %h", k,
                        io_inst_valid, io_inst_pc, io_inst, 32'(8 + 4 * k));
      end
    end
  endtask

  // Redirect with two old requests in flight on a 3-cycle memory.
  task automatic test_redirect();
    int          first_cyc;
    logic [31:0] first_pc;
    logic [31:0] first_inst;
    do_reset();
    lat = 3; io_imem_req_ready = 1'b1; io_inst_ready = 1'b1;
    cycle();
    cycle();
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h103;
    #1;
    total++;
    if ({io_imem_req_valid, io_imem_req_addr, io_inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
      bad++; $display("FAIL redirect_addr: got %b %h inst_valid=%b want 1 00000100 0",
                      io_imem_req_valid, io_imem_req_addr, io_inst_valid);
    end
    cycle();
    io_redirect_valid = 1'b0;
    first_cyc = -1; first_pc = '0; first_inst = '0;
    for (int k = 0; k < 12 && first_cyc < 0; k++) begin
      #1;
      if (io_inst_valid) begin
        first_cyc  = cyc;
        first_pc   = io_inst_pc;
        first_inst = io_inst;
      end
      cycle();
    end
    total++;
    if (first_cyc != 6 - BYP) begin
      bad++; $display("FAIL redirect_latency: got cycle %0d want %0d", first_cyc, 6 - BYP);
    end
    total++;
    if ({first_pc, first_inst} !== {32'h100, mem_word(32'h100)}) begin
      bad++; $display("FAIL redirect_first_inst: got %h %h want 00000100 %h",
                      first_pc, first_inst, mem_word(32'h100));
    end
  endtask

  // Redirect colliding with a response and with decode ready.
  task automatic test_redirect_collide();
    logic [31:0] exp_pc;
    do_reset();
    lat = 1; io_imem_req_ready = 1'b1; io_inst_ready = 1'b0;
    cycle();
    cycle();
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h200;
    io_inst_ready     = 1'b1;
    #1;
    total++;
    if ({io_inst_valid, io_imem_req_addr} !== {1'b0, 32'h200}) begin
      bad++; $display("FAIL collide_redirect_cycle: got %b %h want 0 00000200",
                      io_inst_valid, io_imem_req_addr);
    end
    cycle();
    io_redirect_valid = 1'b0;
    io_inst_ready     = 1'b0;
    #1;
    exp_pc = (BYP != 0) ? 32'h200 : 32'h0;
    total++;
    if ({io_inst_valid, io_inst_pc} !== {1'(BYP), exp_pc}) begin
      bad++; $display("FAIL collide_flushed: got %b %h want %0d %h",
                      io_inst_valid, io_inst_pc, BYP, exp_pc);
    end
    cycle(); #1;
    total++;
    if ({io_inst_valid, io_inst_pc, io_inst} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
      bad++; $display("FAIL collide_new_stream: got %b %h %h want 1 00000200 %h",
                      io_inst_valid, io_inst_pc, io_inst, mem_word(32'h200));
    end
  endtask

  // Memory back-pressure, redirect address masking and fetch PC wrap.
  task automatic test_wrap_stall();
    logic [31:0] exp_pc;
    do_reset();
    lat = 1; io_imem_req_ready = 1'b0; io_inst_ready = 1'b1;
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'hFFFF_FFFE;
    #1;
    total++;
    if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      bad++; $display("FAIL wrap_mask: got %b %h want 1 fffffffc", io_imem_req_valid, io_imem_req_addr);
    end
    cycle();
    io_redirect_valid = 1'b0;
    #1;
    total++;
    if (io_imem_req_addr !== 32'hFFFF_FFFC || fires !== 0) begin
      bad++; $display("FAIL wrap_hold: got %h fires=%0d want fffffffc 0", io_imem_req_addr, fires);
    end
    io_imem_req_ready = 1'b1;
    cycle(); #1;
    total++;
    if (io_imem_req_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: got %h want 00000000", io_imem_req_addr);
    end
    cycle(); #1;
    exp_pc = (BYP != 0) ? 32'h0 : 32'hFFFF_FFFC;
    total++;
    if ({io_inst_valid, io_inst_pc} !== {1'b1, exp_pc}) begin
      bad++; $display("FAIL wrap_inst_pc: got %b %h want 1 %h", io_inst_valid, io_inst_pc, exp_pc);
    end
  endtask

  // Decode field extraction, and same-cycle presentation in the bypass build.
  task automatic test_decode_fields();
    do_reset();
    lat = 1; io_imem_req_ready = 1'b1; io_inst_ready = 1'b1;
    use_fixed  = 1'b1;
    fixed_word = 32'h0020_8033;
    cycle();
    fixed_word = 32'hFE00_50B3;
    for (int k = 0; k < 4 && !io_inst_valid; k++) begin
      #1;
      if (!io_inst_valid) cycle();
    end
    total++;
    if (cyc != 2 - BYP) begin
      bad++; $display("FAIL fields_latency: got cycle %0d want %0d", cyc, 2 - BYP);
    end
    total++;
    if ({io_inst_valid, io_inst_pc, io_opcode, io_funct3, io_funct7} !==
        {1'b1, 32'h0, 7'h33, 3'h0, 7'h00}) begin
      bad++; $display("FAIL fields_add: got %b %h op=%h f3=%h f7=%h want 1 00000000 33 0 00",
                      io_inst_valid, io_inst_pc, io_opcode, io_funct3, io_funct7);
    end
    cycle(); #1;
    total++;
    if ({io_inst_valid, io_inst_pc, io_opcode, io_funct3, io_funct7} !==
        {1'b1, 32'h4, 7'h33, 3'h5, 7'h7F}) begin
      bad++; $display("FAIL fields_second: got %b %h op=%h f3=%h f7=%h want 1 00000004 33 5 7f",
                      io_inst_valid, io_inst_pc, io_opcode, io_funct3, io_funct7);
    end
  endtask

  initial begin
    cyc = 0; lat = 1; fires = 0; use_fixed = 1'b0; fixed_word = '0;
    test_reset();
    test_stream();
    test_redirect();
    test_redirect_collide();
    test_wrap_stall();
    test_decode_fields();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
